rs_latch_arbiter: RTL

RS_LATCH_ARBITER -- requirements
Module: rs_latch_arbiter

---
 rtl/rs_latch_arbiter.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/rs_latch_arbiter.sv
// rs_latch_arbiter: round-robin arbiter serialising write requests from four
// requesters onto four gated RS NOR latches.
//
// Each write runs a SETUP / PULSE / HOLD sequence. During SETUP the set or
// reset line is driven first. During PULSE the gate enable is high for
// PULSE_CYC cycles while the lines stay stable. During HOLD the lines are
// still held and the requester receives a one-cycle ack.
//
// Optional feature: define RS_SKIP_REDUNDANT_EN to short-circuit grants whose
// command matches the value already held in the latch. Such a grant goes
// through a single SKIP cycle with ack and no latch activity.
module rs_latch_arbiter #(
    parameter int PULSE_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] cmd,
    input  logic [7:0] idx,
    output logic [3:0] ack,
    output logic       busy,
    output logic       lat_en,
    output logic [3:0] lat_s,
    output logic [3:0] lat_r,
    output logic [3:0] q_shadow
);

    // Reject pulse widths the 4-bit counter cannot represent (or zero).
    generate
        if (PULSE_CYC < 1 || PULSE_CYC > 15) begin : g_bad_pulse_cyc
            $error("rs_latch_arbiter: PULSE_CYC must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYC);

`ifdef RS_SKIP_REDUNDANT_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        HOLD  = 3'd3,
        SKIP  = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_t;
`endif

    state_t     state_reg;
    logic [1:0] ptr_reg;
    logic [3:0] cnt_reg;
    logic [1:0] gnt_id_reg;
    logic [1:0] gnt_lat_reg;
    logic       gnt_cmd_reg;
    logic [3:0] ack_reg;
    logic       busy_reg;
    logic       lat_en_reg;
    logic [3:0] lat_s_reg;
    logic [3:0] lat_r_reg;
    logic [3:0] q_shadow_reg;

    // Requests rotated so that bit 0 is the requester at the round-robin pointer.
    logic [3:0] rot_req;
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rot
            assign rot_req[gi] = req[ptr_reg + 2'(gi)];
        end
    endgenerate

    logic       grant_valid;
    logic [1:0] grant_off;
    logic [1:0] grant_id;
    logic       sel_cmd;
    logic [1:0] sel_lat;
    logic [3:0] sel_onehot;

    // Pick the first requester at or after the pointer and fetch its command and target latch.
    always_comb begin
        grant_valid = |req;
        grant_off   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (rot_req[i]) begin
                grant_off = 2'(i);
            end
        end
        grant_id   = ptr_reg + grant_off;
        sel_cmd    = cmd[grant_id];
        sel_lat    = idx[{grant_id, 1'b0} +: 2];
        sel_onehot = 4'b0001 << sel_lat;
    end

    // Arbitration and latch-drive sequencer. Every output is produced by a register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            ptr_reg      <= 2'd0;
            cnt_reg      <= 4'd0;
            gnt_id_reg   <= 2'd0;
            gnt_lat_reg  <= 2'd0;
            gnt_cmd_reg  <= 1'b0;
            ack_reg      <= 4'd0;
            busy_reg     <= 1'b0;
            lat_en_reg   <= 1'b0;
            lat_s_reg    <= 4'd0;
            lat_r_reg    <= 4'd0;
            q_shadow_reg <= 4'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    ack_reg    <= 4'd0;
                    lat_en_reg <= 1'b0;
                    lat_s_reg  <= 4'd0;
                    lat_r_reg  <= 4'd0;
                    if (grant_valid) begin
                        // Capture the grant so that later input changes cannot disturb the write.
                        gnt_id_reg  <= grant_id;
                        gnt_lat_reg <= sel_lat;
                        gnt_cmd_reg <= sel_cmd;
                        ptr_reg     <= grant_id + 2'd1;
                        busy_reg    <= 1'b1;
`ifdef RS_SKIP_REDUNDANT_EN
                        if (sel_cmd == q_shadow_reg[sel_lat]) begin
                            // The latch already holds this value, so acknowledge without pulsing it.
                            ack_reg   <= 4'b0001 << grant_id;
                            state_reg <= SKIP;
                        end else begin
                            lat_s_reg <= sel_cmd ? sel_onehot : 4'd0;
                            lat_r_reg <= sel_cmd ? 4'd0 : sel_onehot;
                            state_reg <= SETUP;
                        end
`else
                        lat_s_reg <= sel_cmd ? sel_onehot : 4'd0;
                        lat_r_reg <= sel_cmd ? 4'd0 : sel_onehot;
                        state_reg <= SETUP;
`endif
                    end
                end
                SETUP: begin
                    lat_en_reg <= 1'b1;
                    cnt_reg    <= 4'd1;
                    state_reg  <= PULSE;
                end
                PULSE: begin
                    if (cnt_reg == PULSE_LAST) begin
                        // Close the gate while S/R stay held, then report completion.
                        lat_en_reg                <= 1'b0;
                        ack_reg                   <= 4'b0001 << gnt_id_reg;
                        q_shadow_reg[gnt_lat_reg] <= gnt_cmd_reg;
                        state_reg                 <= HOLD;
                    end else begin
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end
                HOLD: begin
                    ack_reg   <= 4'd0;
                    lat_s_reg <= 4'd0;
                    lat_r_reg <= 4'd0;
                    cnt_reg   <= 4'd0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
`ifdef RS_SKIP_REDUNDANT_EN
                SKIP: begin
                    ack_reg   <= 4'd0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
`endif
                default: begin
                    ack_reg    <= 4'd0;
                    busy_reg   <= 1'b0;
                    lat_en_reg <= 1'b0;
                    lat_s_reg  <= 4'd0;
                    lat_r_reg  <= 4'd0;
                    cnt_reg    <= 4'd0;
                    state_reg  <= IDLE;
                end
            endcase
        end
    end

    assign ack      = ack_reg;
    assign busy     = busy_reg;
    assign lat_en   = lat_en_reg;
    assign lat_s    = lat_s_reg;
    assign lat_r    = lat_r_reg;
    assign q_shadow = q_shadow_reg;

endmodule
